// File: rtl/counter_ctrl_pkg.sv
// Shared types for counter_ctrl: FSM state encoding and default widths.
package counter_ctrl_pkg;

   localparam int CC_N_DEFAULT = 4;
   localparam int CC_R_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/counter_ctrl.sv
// Sequencer for a 74x163-style counter: load preset, reload on rco for reps periods, pulse done.
// Latency: LOAD one cycle after start, RUN reps*(2^N-preset) cycles, then a one-cycle DONE.
// Backpressure: none; start ignored while busy/DONE. Optional port pause under COUNTER_CTRL_PAUSE_EN.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int N = CC_N_DEFAULT,
   parameter int R = CC_R_DEFAULT
)
(
   input  logic         clk,
   input  logic         clr,
   input  logic         start,
   input  logic         abort,
`ifdef COUNTER_CTRL_PAUSE_EN
   input  logic         pause,
`endif
   input  logic [N-1:0] preset,
   input  logic [R-1:0] reps,
   input  logic         cnt_rco,
   output logic         cnt_ld,
   output logic [N-1:0] cnt_din,
   output logic         cnt_enp,
   output logic         cnt_ent,
   output logic         busy,
   output logic         done,
   output logic [R-1:0] rep_left
);

   state_t       state;
   logic [N-1:0] preset_q;
   logic [R-1:0] rep_q;
   logic         hold;
   logic         in_run;
   logic         take_rco;

`ifdef COUNTER_CTRL_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   assign in_run   = (state == S_RUN);
   // While paused the counter's rco is left pending, so a terminal count is not lost.
   assign take_rco = in_run & ~hold & cnt_rco;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= S_IDLE;
         preset_q <= '0;
         rep_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_LOAD;
                  preset_q <= preset;
                  rep_q    <= (reps == '0) ? R'(1) : reps;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  state <= S_IDLE;
                  rep_q <= '0;
               end else begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state <= S_IDLE;
                  rep_q <= '0;
               end else if (take_rco) begin
                  if (rep_q != R'(1)) begin
                     rep_q <= rep_q - R'(1);
                  end else begin
                     rep_q <= '0;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Load beats count on the counter, so a terminal count restarts the period at preset_q.
   assign cnt_ld   = ~((state == S_LOAD) | take_rco);
   assign cnt_din  = preset_q;
   assign cnt_enp  = in_run & ~hold;
   assign cnt_ent  = in_run;
   assign busy     = (state == S_LOAD) | in_run;
   assign done     = (state == S_DONE);
   assign rep_left = rep_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl driving a behavioural 74x163 counter; expectations come from period arithmetic.
module tb_counter_ctrl;

   localparam int N = 4;
   localparam int R = 4;

   logic         clk = 1'b0;
   logic         clr;
   logic         start;
   logic         abort;
`ifdef COUNTER_CTRL_PAUSE_EN
   logic         pause;
`endif
   logic [N-1:0] preset;
   logic [R-1:0] reps;
   logic         cnt_rco;
   logic         cnt_ld;
   logic [N-1:0] cnt_din;
   logic         cnt_enp;
   logic         cnt_ent;
   logic         busy;
   logic         done;
   logic [R-1:0] rep_left;
   logic [N-1:0] q;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   counter_ctrl #(.N(N), .R(R)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .abort    (abort),
`ifdef COUNTER_CTRL_PAUSE_EN
      .pause    (pause),
`endif
      .preset   (preset),
      .reps     (reps),
      .cnt_rco  (cnt_rco),
      .cnt_ld   (cnt_ld),
      .cnt_din  (cnt_din),
      .cnt_enp  (cnt_enp),
      .cnt_ent  (cnt_ent),
      .busy     (busy),
      .done     (done),
      .rep_left (rep_left)
   );

   // The driven counter: sync load beats count, rco gated by ent, shares clr.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         q <= '0;
      else if (!cnt_ld)
         q <= cnt_din;
      else if (cnt_enp && cnt_ent)
         q <= q + 1'b1;
   end
   assign cnt_rco = cnt_ent & (q == '1);

   // {busy, done, cnt_ld, cnt_enp, cnt_ent, rep_left, q}
   wire [12:0] obs = {busy, done, cnt_ld, cnt_enp, cnt_ent, rep_left, q};

   task automatic test_reset;
      clr = 1'b0; start = 1'b0; abort = 1'b0; preset = '0; reps = '0;
`ifdef COUNTER_CTRL_PAUSE_EN
      pause = 1'b0;
`endif
      #12;
      tests++;
      if (obs !== 13'b00100_0000_0000 || cnt_din !== 4'd0) begin
         fails++;
         $display("FAIL reset_state: got %h din %h want 0400 din 0", obs, cnt_din);
      end
      @(negedge clk);
      clr = 1'b1;
      preset = 4'd9;
      reps = 4'd5;
      repeat (3) @(negedge clk);
      tests++;
      if (obs !== 13'b00100_0000_0000 || cnt_din !== 4'd0) begin
         fails++;
         $display("FAIL reset_idle: got %h din %h want 0400 din 0", obs, cnt_din);
      end
   endtask

   task automatic test_run(input int p, input int r);
      int re, per, len;
      logic ld;
      logic [12:0] want;
      re  = (r == 0) ? 1 : r;
      per = (1 << N) - p;
      len = re * per;
      @(negedge clk);
      preset = N'(p); reps = R'(r); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (obs[12:4] !== {5'b10000, R'(re)}) begin
         fails++;
         $display("FAIL run_load p=%0d r=%0d: got %h want %h", p, r, obs[12:4], {5'b10000, R'(re)});
      end
      preset = N'($urandom);
      reps   = R'($urandom);
      for (int j = 0; j < len; j++) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         ld   = (j % per == per - 1) ? 1'b0 : 1'b1;
         want = {2'b10, ld, 2'b11, R'(re - j / per), N'(p + j % per)};
         tests++;
         if (obs !== want) begin
            fails++;
            $display("FAIL run_cycle p=%0d r=%0d j=%0d: got %h want %h", p, r, j, obs, want);
         end
      end
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      want = {5'b01100, R'(0), N'(p)};
      tests++;
      if (obs !== want || cnt_din !== N'(p)) begin
         fails++;
         $display("FAIL run_done p=%0d r=%0d: got %h din %h want %h din %h", p, r, obs, cnt_din, want, N'(p));
      end
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      want = {5'b00100, R'(0), N'(p)};
      tests++;
      if (obs !== want) begin
         fails++;
         $display("FAIL run_idle p=%0d r=%0d: got %h want %h", p, r, obs, want);
      end
      @(negedge clk);
      tests++;
      if (obs !== want) begin
         fails++;
         $display("FAIL run_no_restart p=%0d r=%0d: got %h want %h", p, r, obs, want);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++)
         test_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)));
   endtask

   task automatic test_abort;
      int k, dones;
      logic [12:0] want;
      @(negedge clk);
      preset = 4'd12; reps = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(busy && cnt_rco) && k < 40) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k !== 4 || rep_left !== 4'd3) begin
         fails++;
         $display("FAIL abort_rco_reach: got cycle %0d rep %0d want cycle 4 rep 3", k, rep_left);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      want = {5'b00100, R'(0), N'(12)};
      tests++;
      if (obs !== want) begin
         fails++;
         $display("FAIL abort_rco: got %h want %h", obs, want);
      end
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      tests++;
      if (dones !== 0) begin
         fails++;
         $display("FAIL abort_quiet: got %0d active cycles want 0", dones);
      end
      preset = 4'd0; reps = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (obs[12:4] !== 9'b00100_0000) begin
         fails++;
         $display("FAIL abort_load: got %h want 040", obs[12:4]);
      end
      preset = 4'd14; reps = 4'd1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      tests++;
      if (obs[12:4] !== 9'b10000_0001) begin
         fails++;
         $display("FAIL abort_idle: got %h want 101", obs[12:4]);
      end
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k !== 3) begin
         fails++;
         $display("FAIL abort_idle_done: got %0d cycles want 3", k);
      end
      @(negedge clk);
   endtask

   task automatic test_clr_midrun;
      @(negedge clk);
      preset = 4'd5; reps = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 clr = 1'b0;
      #1;
      tests++;
      if (obs !== 13'b00100_0000_0000 || cnt_din !== 4'd0) begin
         fails++;
         $display("FAIL clr_async: got %h din %h want 0400 din 0", obs, cnt_din);
      end
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      tests++;
      if (obs !== 13'b00100_0000_0000) begin
         fails++;
         $display("FAIL clr_release: got %h want 0400", obs);
      end
   endtask

`ifdef COUNTER_CTRL_PAUSE_EN
   task automatic test_pause;
      int k;
      @(negedge clk);
      preset = 4'd13; reps = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      pause = 1'b1;
      repeat (4) begin
         @(negedge clk);
         tests++;
         if (obs !== {5'b10101, R'(1), N'(13)}) begin
            fails++;
            $display("FAIL pause_hold: got %h want %h", obs, {5'b10101, R'(1), N'(13)});
         end
      end
      pause = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k !== 3) begin
         fails++;
         $display("FAIL pause_resume: got %0d cycles want 3", k);
      end
      @(negedge clk);
      preset = 4'd15; reps = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      pause = 1'b1;
      repeat (3) begin
         @(negedge clk);
         tests++;
         if (obs !== {5'b10101, R'(2), N'(15)}) begin
            fails++;
            $display("FAIL pause_rco: got %h want %h", obs, {5'b10101, R'(2), N'(15)});
         end
      end
      pause = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k !== 2) begin
         fails++;
         $display("FAIL pause_rco_resume: got %0d cycles want 2", k);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset;
      test_run(10, 1);
      test_run(12, 3);
      test_run(10, 0);
      test_run(15, 2);
      test_run(0, 1);
      test_random;
      test_abort;
      test_clr_midrun;
`ifdef COUNTER_CTRL_PAUSE_EN
      test_pause;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400us;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
